// File: rtl/gs_elim_sched_pkg.sv
// Shared definitions for the gs_elim_sched scheduler: FSM state type and
// host_rw encoding.
package gs_elim_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } sched_state_e;

    localparam logic HOST_WR = 1'b1;
    localparam logic HOST_RD = 1'b0;

endpackage : gs_elim_sched_pkg

// File: rtl/gs_elim_sched_rd_pipe.sv
// gs_rd_pipe: DEPTH-deep valid shift register tracking host reads in flight.
// empty_o is high when no read will still be returning in the next cycle,
// i.e. only the output stage (whose data is on the RAM bus now) may be set.
module gs_rd_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic vld_i,
    output logic vld_o,
    output logic empty_o
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;
    logic             inflight;

    // Shift next-state and in-flight detection over all but the output stage.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = vld_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        inflight = vld_i;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            inflight = inflight | pipe_q[i];
        end
    end

    // Pipe register with synchronous active-low clear.
    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign vld_o   = pipe_q[DEPTH-1];
    assign empty_o = ~inflight;

endmodule : gs_rd_pipe

// File: rtl/gs_elim_sched.sv
// gs_elim_sched: scheduler and RAM-port arbiter for the Gaussian-elimination
// engine. Host accesses are granted only in IDLE; a run request drains
// outstanding host reads, pulses eng_start and gives the RAM to the engine
// until eng_finish.
// Optional watchdog: define GS_SCHED_TIMEOUT_EN.
module gs_elim_sched
    import gs_elim_sched_pkg::*;
#(
    parameter int DAT_W      = 16,
    parameter int DAT_D      = 8,
    parameter int READ_DELAY = 2,
    parameter int MAX_CYC    = 65535,
    parameter int AW         = $clog2(DAT_D)   // derived; leave at default
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             run,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    input  logic             host_req,
    input  logic             host_rw,
    input  logic [AW-1:0]    host_addr,
    input  logic [DAT_W-1:0] host_wdat,
    output logic             host_gnt,
    output logic [DAT_W-1:0] host_rdat,
    output logic             host_rvalid,
    output logic             eng_start,
    input  logic             eng_finish,
    output logic             eng_rst_b,
    input  logic [AW-1:0]    eng_addr,
    input  logic             eng_rw,
    input  logic [DAT_W-1:0] eng_wdat,
    output logic [DAT_W-1:0] eng_rdat,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rw,
    output logic [DAT_W-1:0] mem_dout,
    input  logic [DAT_W-1:0] mem_din
);

    sched_state_e state_q, state_d;
    logic         done_q, done_d;
    logic         pipe_empty;

`ifdef GS_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;
`else
    logic unused_max_cyc;
    assign unused_max_cyc = (MAX_CYC > 0);
`endif

    assign host_gnt  = host_req & (state_q == S_IDLE) & ~run;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign eng_start = (state_q == S_START);
    assign host_rdat = mem_din;
    assign eng_rdat  = mem_din;

    gs_rd_pipe #(
        .DEPTH(READ_DELAY)
    ) u_rd_pipe (
        .clk_i  (clk),
        .rst_b_i(rst_b),
        .vld_i  (host_gnt & (host_rw == HOST_RD)),
        .vld_o  (host_rvalid),
        .empty_o(pipe_empty)
    );

    // RAM port mux: host when granted, engine in START/RUN, otherwise parked at zero.
    always_comb begin
        mem_addr = '0;
        mem_rw   = 1'b0;
        mem_dout = '0;
        if (host_gnt) begin
            mem_addr = host_addr;
            mem_rw   = host_rw;
            mem_dout = host_wdat;
        end else if (state_q == S_START || state_q == S_RUN) begin
            mem_addr = eng_addr;
            mem_rw   = eng_rw;
            mem_dout = eng_wdat;
        end
    end

    // Next-state and pulse logic for the IDLE->DRAIN->START->RUN sequence.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
`ifdef GS_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
        abort_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_DRAIN;
`ifdef GS_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_DRAIN: begin
                // Leave once the last in-flight read is on the bus this cycle,
                // so START never overlaps returning host data.
                if (pipe_empty) begin
                    state_d = S_START;
                end
`ifdef GS_SCHED_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (eng_finish) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`ifdef GS_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(MAX_CYC)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and done-pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

`ifdef GS_SCHED_TIMEOUT_EN
    // Watchdog counter, sticky error flag and one-cycle engine abort.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    assign err_timeout = err_q;
    assign eng_rst_b   = rst_b & ~abort_q;
`else
    assign err_timeout = 1'b0;
    assign eng_rst_b   = rst_b;
`endif

endmodule : gs_elim_sched

// File: tb/tb_gs_elim_sched.sv
// Self-checking bench for gs_elim_sched: table-driven host accesses,
// randomized host traffic against a queue/array reference, and hand-written
// run/drain/reset/watchdog sequences.
module tb_gs_elim_sched;

    localparam int DAT_W      = 16;
    localparam int DAT_D      = 8;
    localparam int READ_DELAY = 2;
    localparam int MAX_CYC    = 16;
    localparam int AW         = $clog2(DAT_D);
`ifdef GS_SCHED_TIMEOUT_EN
    localparam int FIN_DLY    = 10;
`else
    localparam int FIN_DLY    = 40;
`endif

    logic             clk = 1'b0;
    logic             rst_b;
    logic             run;
    logic             busy, done, err_timeout;
    logic             host_req, host_rw;
    logic [AW-1:0]    host_addr;
    logic [DAT_W-1:0] host_wdat;
    logic             host_gnt;
    logic [DAT_W-1:0] host_rdat;
    logic             host_rvalid;
    logic             eng_start, eng_finish, eng_rst_b;
    logic [AW-1:0]    eng_addr;
    logic             eng_rw;
    logic [DAT_W-1:0] eng_wdat, eng_rdat;
    logic [AW-1:0]    mem_addr;
    logic             mem_rw;
    logic [DAT_W-1:0] mem_dout, mem_din;

    gs_elim_sched #(
        .DAT_W     (DAT_W),
        .DAT_D     (DAT_D),
        .READ_DELAY(READ_DELAY),
        .MAX_CYC   (MAX_CYC)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .run        (run),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .host_req   (host_req),
        .host_rw    (host_rw),
        .host_addr  (host_addr),
        .host_wdat  (host_wdat),
        .host_gnt   (host_gnt),
        .host_rdat  (host_rdat),
        .host_rvalid(host_rvalid),
        .eng_start  (eng_start),
        .eng_finish (eng_finish),
        .eng_rst_b  (eng_rst_b),
        .eng_addr   (eng_addr),
        .eng_rw     (eng_rw),
        .eng_wdat   (eng_wdat),
        .eng_rdat   (eng_rdat),
        .mem_addr   (mem_addr),
        .mem_rw     (mem_rw),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din)
    );

    always #5 clk = ~clk;

    // Single-port RAM with READ_DELAY-cycle read latency.
    logic [DAT_W-1:0] ram [DAT_D];
    logic [DAT_W-1:0] rdp [READ_DELAY];
    always @(posedge clk) begin
        if (mem_rw) ram[mem_addr] <= mem_dout;
        rdp[0] <= ram[mem_addr];
        for (int i = 1; i < READ_DELAY; i++) rdp[i] <= rdp[i-1];
    end
    assign mem_din = rdp[READ_DELAY-1];

    int checks   = 0;
    int failures = 0;

    logic [DAT_W-1:0] exp_mem [DAT_D];

    typedef struct {
        int               due;
        logic [DAT_W-1:0] data;
    } rd_t;
    rd_t rq[$];

    typedef struct {
        logic             req;
        logic             rw;
        logic [AW-1:0]    addr;
        logic [DAT_W-1:0] wdat;
        logic             exp_gnt;
        logic             exp_rvalid;
        logic [DAT_W-1:0] exp_rdat;
    } vec_t;
    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Move to the start of the next cycle; inputs are driven after this.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [DAT_W-1:0] exp_rd;

        rst_b      = 1'b0;
        run        = 1'b0;
        host_req   = 1'b0;
        host_rw    = 1'b0;
        host_addr  = '0;
        host_wdat  = '0;
        eng_finish = 1'b0;
        eng_addr   = AW'(5);
        eng_rw     = 1'b0;
        eng_wdat   = DAT_W'(16'hBEEF);
        for (int i = 0; i < DAT_D; i++) exp_mem[i] = '0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        #2;
        chk("rst_busy",      busy,        0);
        chk("rst_done",      done,        0);
        chk("rst_eng_start", eng_start,   0);
        chk("rst_rvalid",    host_rvalid, 0);
        chk("rst_err",       err_timeout, 0);
        chk("rst_eng_rst_b", eng_rst_b,   0);
        tick();
        rst_b = 1'b1;
        #2;
        chk("rel_eng_rst_b", eng_rst_b, 1);
        chk("rel_busy",      busy,      0);

        // ---------------- table: write rows, read 3,4 back-to-back ----------------
        for (int i = 0; i < 8; i++)
            vt[i] = '{1'b1, 1'b1, AW'(i), DAT_W'(i + 1), 1'b1, 1'b0, DAT_W'(0)};
        vt[8]  = '{1'b1, 1'b0, AW'(3), DAT_W'(0), 1'b1, 1'b0, DAT_W'(0)};
        vt[9]  = '{1'b1, 1'b0, AW'(4), DAT_W'(0), 1'b1, 1'b0, DAT_W'(0)};
        vt[10] = '{1'b0, 1'b0, AW'(0), DAT_W'(0), 1'b0, 1'b1, DAT_W'(4)};
        vt[11] = '{1'b0, 1'b0, AW'(0), DAT_W'(0), 1'b0, 1'b1, DAT_W'(5)};
        vt[12] = '{1'b0, 1'b0, AW'(0), DAT_W'(0), 1'b0, 1'b0, DAT_W'(0)};
        for (int i = 0; i < 13; i++) begin
            tick();
            host_req  = vt[i].req;
            host_rw   = vt[i].rw;
            host_addr = vt[i].addr;
            host_wdat = vt[i].wdat;
            #2;
            chk("tbl_gnt",    host_gnt,    vt[i].exp_gnt);
            chk("tbl_rvalid", host_rvalid, vt[i].exp_rvalid);
            if (vt[i].exp_rvalid) chk("tbl_rdat", host_rdat, vt[i].exp_rdat);
            if (vt[i].exp_gnt) begin
                chk("tbl_mem_addr", mem_addr, vt[i].addr);
                chk("tbl_mem_rw",   mem_rw,   vt[i].rw);
                if (vt[i].rw) chk("tbl_mem_dout", mem_dout, vt[i].wdat);
            end else begin
                chk("tbl_mem_rw_idle", mem_rw, 0);
            end
            if (vt[i].req && vt[i].rw) exp_mem[vt[i].addr] = vt[i].wdat;
        end

        // ---------------- randomized host traffic vs reference ----------------
        for (int c = 0; c < 300 + READ_DELAY + 1; c++) begin
            tick();
            host_req  = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            host_rw   = 1'($urandom_range(0, 1));
            host_addr = AW'($urandom_range(0, DAT_D - 1));
            host_wdat = DAT_W'($urandom);
            #2;
            chk("rnd_gnt", host_gnt, host_req);
            if (rq.size() > 0 && rq[0].due == c) begin
                chk("rnd_rvalid", host_rvalid, 1);
                chk("rnd_rdat",   host_rdat,   rq[0].data);
                void'(rq.pop_front());
            end else begin
                chk("rnd_rvalid_idle", host_rvalid, 0);
            end
            if (host_req) begin
                if (host_rw) exp_mem[host_addr] = host_wdat;
                else rq.push_back('{due: c + READ_DELAY, data: exp_mem[host_addr]});
            end
        end
        chk("rnd_queue_empty", rq.size(), 0);

        // ---------------- drain: read at t, run at t+1 ----------------
        tick();
        host_req = 1'b1; host_rw = 1'b0; host_addr = AW'(2);
        exp_rd = exp_mem[2];
        #2;
        chk("drn_gnt_t", host_gnt, 1);
        tick();
        run = 1'b1;
        #2;
        chk("drn_collide_gnt", host_gnt, 0);
        chk("drn_busy_t1",     busy,     0);
        tick();
        run = 1'b0;
        #2;
        chk("drn_busy_t2",   busy,        1);
        chk("drn_gnt_t2",    host_gnt,    0);
        chk("drn_rvalid_t2", host_rvalid, 1);
        chk("drn_rdat_t2",   host_rdat,   exp_rd);
        chk("drn_start_t2",  eng_start,   0);
        chk("drn_mem_addr",  mem_addr,    0);
        tick();
        #2;
        chk("drn_start_t3",   eng_start,   1);
        chk("drn_rvalid_t3",  host_rvalid, 0);
        chk("eng_mux_addr",   mem_addr,    eng_addr);
        chk("eng_mux_dout",   mem_dout,    eng_wdat);
        chk("eng_mux_rw",     mem_rw,      eng_rw);
        chk("eng_rdat",       eng_rdat,    mem_din);
        for (int k = 4; k <= 3 + FIN_DLY; k++) begin
            tick();
            run        = (k == 10);
            eng_finish = (k == 3 + FIN_DLY);
            #2;
            chk("run_start_low", eng_start, 0);
            chk("run_busy",      busy,      1);
            chk("run_done_low",  done,      0);
            chk("run_gnt_low",   host_gnt,  0);
            chk("run_rvalid",    host_rvalid, 0);
            chk("run_err",       err_timeout, 0);
            chk("run_eng_rst_b", eng_rst_b, 1);
        end
        tick();
        run = 1'b0; eng_finish = 1'b0;
        #2;
        chk("fin_done", done,     1);
        chk("fin_busy", busy,     0);
        chk("fin_gnt",  host_gnt, 1);
        tick();
        host_req = 1'b0; eng_finish = 1'b1;
        #2;
        chk("fin_done_once", done, 0);
        chk("fin_no_start",  eng_start, 0);
        tick();
        eng_finish = 1'b0;
        #2;
        chk("idle_finish_ignored", done, 0);
        chk("idle_finish_busy",    busy, 0);

        // ---------------- reset mid-run, reset clears read pipe ----------------
        tick();
        run = 1'b1;
        #2;
        chk("rr_busy0", busy, 0);
        tick();
        run = 1'b0;
        #2;
        chk("rr_busy1",  busy,      1);
        chk("rr_start1", eng_start, 0);
        tick();
        #2;
        chk("rr_start2", eng_start, 1);
        tick();
        #2;
        chk("rr_run_busy", busy, 1);
        tick();
        rst_b = 1'b0;
        #2;
        chk("rr_eng_rst_b_low", eng_rst_b, 0);
        tick();
        rst_b = 1'b1;
        #2;
        chk("rr_busy_after", busy,      0);
        chk("rr_no_done",    done,      0);
        chk("rr_no_start",   eng_start, 0);
        chk("rr_eng_rst_b",  eng_rst_b, 1);
        tick();
        host_req = 1'b1; host_rw = 1'b0; host_addr = AW'(1);
        #2;
        chk("rr_gnt", host_gnt, 1);
        chk("rr_no_done2", done, 0);
        tick();
        host_req = 1'b0; rst_b = 1'b0;
        #2;
        tick();
        rst_b = 1'b1;
        #2;
        chk("rr_pipe_cleared", host_rvalid, 0);
        tick();
        #2;
        chk("rr_pipe_cleared2", host_rvalid, 0);

`ifdef GS_SCHED_TIMEOUT_EN
        // ---------------- watchdog: engine never finishes ----------------
        tick();
        run = 1'b1;
        #2;
        tick();
        run = 1'b0;
        #2;
        tick();
        #2;
        chk("wd_start", eng_start, 1);
        for (int k = 3; k <= 3 + MAX_CYC; k++) begin
            tick();
            #2;
            chk("wd_run_eng_rst_b", eng_rst_b, 1);
            chk("wd_run_done",      done,      0);
            chk("wd_run_busy",      busy,      1);
        end
        tick();
        #2;
        chk("wd_eng_rst_b_low", eng_rst_b,   0);
        chk("wd_err_set",       err_timeout, 1);
        chk("wd_done",          done,        1);
        chk("wd_busy",          busy,        0);
        tick();
        #2;
        chk("wd_eng_rst_b_back", eng_rst_b,   1);
        chk("wd_err_sticky",     err_timeout, 1);
        chk("wd_done_once",      done,        0);
        tick();
        run = 1'b1;
        #2;
        chk("wd_err_before_run", err_timeout, 1);
        tick();
        run = 1'b0;
        #2;
        chk("wd_err_cleared", err_timeout, 0);
        chk("wd_rerun_busy",  busy,        1);
        tick();
        #2;
        chk("wd_rerun_start", eng_start, 1);
        tick();
        eng_finish = 1'b1;
        #2;
        tick();
        eng_finish = 1'b0;
        #2;
        chk("wd_rerun_done", done,        1);
        chk("wd_rerun_err",  err_timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gs_elim_sched

// File: doc/gs_elim_sched.md
Name: gs_elim_sched

Overview:
- Scheduler and memory-port arbiter for the Gaussian-elimination engine (gs_elim_top) and its k×l single-port matrix RAM.
- The host side loads and reads back matrix rows through a per-access req/gnt port.
- A run request hands the RAM exclusively to the engine. The scheduler waits for in-flight host reads to drain, pulses the engine start, and returns the RAM to the host on engine finish.

Parameters:
- DAT_W, `l, row width in bits.
- DAT_D, `k, number of rows.
- READ_DELAY, 2, RAM read latency in cycles, from address to mem_din valid; must be ≥1.
- MAX_CYC, 65535, watchdog limit in cycles; used only with GS_SCHED_TIMEOUT_EN.
- AW, `CLOG2(DAT_D), address width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_b  in  1  synchronous active-low reset.
- run  in  1  single-cycle request for one elimination pass.
- busy  out  1  high from run acceptance until done.
- done  out  1  one-cycle pulse when the pass completes or aborts.
- err_timeout  out  1  sticky watchdog flag; cleared by the next accepted run.
- host_req  in  1  host access request.
- host_rw  in  1  1 = write, 0 = read.
- host_addr  in  AW  host row address.
- host_wdat  in  DAT_W  host write data.
- host_gnt  out  1  access accepted this cycle.
- host_rdat  out  DAT_W  read data.
- host_rvalid  out  1  host_rdat valid.
- eng_start  out  1  start pulse to the engine.
- eng_finish  in  1  engine done pulse.
- eng_rst_b  out  1  engine reset, active-low.
- eng_addr  in  AW  engine row address.
- eng_rw  in  1  engine write enable.
- eng_wdat  in  DAT_W  engine write data.
- eng_rdat  out  DAT_W  read data to the engine.
- mem_addr  out  AW  RAM address.
- mem_rw  out  1  RAM write enable.
- mem_dout  out  DAT_W  RAM write data.
- mem_din  in  DAT_W  RAM read data.

Behaviour:
- Reset (rst_b=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, eng_start, err_timeout, host_rvalid, and the read pipe all clear to 0.
  - eng_rst_b follows rst_b.
  - Reset mid-pass abandons the pass with no done pulse.
- State machine IDLE→DRAIN→START→RUN→IDLE:
  - IDLE: run=1 → DRAIN, busy=1, err_timeout cleared. run in any other state is ignored.
  - DRAIN: wait until the read pipe is empty, at most READ_DELAY cycles, then → START.
  - START: eng_start=1 for exactly one cycle, then → RUN.
  - RUN: eng_finish=1 → IDLE, done=1 for one cycle, busy=0 in the same cycle as done.
  - eng_finish outside RUN is ignored.
- Host grant:
  - host_gnt = host_req & (state==IDLE) & ~run, combinational.
  - run wins when it coincides with host_req; the host must hold host_req and retry.
- RAM mux:
  - IDLE with grant: mem_* driven from host_*.
  - START and RUN: mem_* driven from eng_*.
  - Otherwise: mem_addr=0, mem_rw=0, mem_dout=0.
  - eng_rdat = mem_din at all times.
- Read pipe:
  - READ_DELAY-deep shift register of (host_gnt & ~host_rw).
  - host_rvalid = pipe output; host_rdat = mem_din, passed through combinationally.
  - Back-to-back host reads give one valid per cycle.
  - Writes generate no rvalid.
- Engine never sees a cycle in which host read data is still returning.
- Address ≥ DAT_D: passed through unchanged; range checking is the RAM's responsibility.

Optional Feature:
- Macro: GS_SCHED_TIMEOUT_EN.
- Defined:
  - Cycle counter, $clog2(MAX_CYC+1) bits, clears on entry to START and counts in RUN.
  - When the count reaches MAX_CYC without eng_finish:
    - eng_rst_b is driven 0 for one cycle.
    - err_timeout is set.
    - done pulses; state → IDLE.
- Undefined:
  - No counter; eng_rst_b = rst_b; err_timeout is tied to 0.

Decomposition:
- Shared package/header (define.v): state encoding constants S_IDLE/S_DRAIN/S_START/S_RUN, the host_rw encoding, and reuse of `CLOG2.
- One sub-module: gs_rd_pipe, the READ_DELAY valid shift register with an empty flag.

Test Plan:
- Host writes rows 0..DAT_D-1 with values 0x1,0x2,...; then reads rows 3,4 back-to-back → host_rvalid at cycles t+2 and t+3 (READ_DELAY=2), data 0x4 then 0x5.
- Host read granted at cycle t, run at t+1 → DRAIN lasts until rvalid at t+2; eng_start at t+3; no host_gnt while busy.
- run and host_req asserted in the same IDLE cycle → host_gnt=0, busy=1 next cycle; host access granted after done.
- Engine model asserts eng_finish 40 cycles after start → done exactly one cycle, then busy=0 and host_gnt returns; run pulsed during RUN is ignored (no second eng_start).
- rst_b=0 during RUN → next cycle IDLE, busy=0, no done, read pipe empty.
- With GS_SCHED_TIMEOUT_EN and MAX_CYC=16, engine never finishes → eng_rst_b low one cycle at count 16, err_timeout=1, done pulse; next run clears err_timeout.
